// File: rtl/riscv_pkg.sv
// Shared row-arbiter types and index-width helper; no logic, no latency.
// Used by the row arbiter and its round-robin picker.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      FLUSH  = 2'd2,
      NOTIFY = 2'd3
   } arb_state_t;

   // Core index width; a single-core row still needs one bit for the pointer.
   function automatic int arb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ARB_NUM_CORES_DEFAULT = 8;
   localparam int ARB_IDX_W             = arb_idx_w(ARB_NUM_CORES_DEFAULT);

endpackage

// File: rtl/uram_row_arbiter_rr_pick.sv
// Round-robin picker: first eligible bit at or above rr_ptr, wrapping; purely combinational.
// No backpressure; the caller decides when to register the pick.
module rr_pick
   import riscv_pkg::*;
#(
   parameter int NUM_CORES = 8,
   parameter int IDX_W     = arb_idx_w(NUM_CORES)
) (
   input  logic [NUM_CORES-1:0] eligible,
   input  logic [IDX_W-1:0]     rr_ptr,
   output logic [NUM_CORES-1:0] pick,
   output logic                 valid
);

   logic found;

   // Offset i walks the ring starting at rr_ptr; the first hit wins.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         for (int k = 0; k < NUM_CORES; k++) begin
            if (!found && eligible[k] && (k == ((int'(rr_ptr) + i) % NUM_CORES))) begin
               pick[k] = 1'b1;
               found   = 1'b1;
            end
         end
      end
   end

   assign valid = found;

endmodule

// File: rtl/uram_row_arbiter.sv
// Row URAM write-port arbiter with per-epoch barrier; grant 1 cycle after request, mux combinational.
// A granted core keeps the port while req|locked; others wait, done cores wait for the drain.
module uram_row_arbiter
   import riscv_pkg::*;
#(
   parameter int NUM_CORES = 8,
   parameter int ADDR_W    = 12,
   parameter int DATA_W    = 32,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_CORES-1:0]        i_core_req,
   input  logic [NUM_CORES-1:0]        i_core_locked,
   output logic [NUM_CORES-1:0]        o_core_grant,
   output logic [NUM_CORES-1:0]        o_uram_emptied,
   input  logic [NUM_CORES-1:0]        i_uram_en,
   input  logic [NUM_CORES-1:0]        i_uram_wr_en,
   input  logic [NUM_CORES*ADDR_W-1:0] i_uram_addr,
   input  logic [NUM_CORES*DATA_W-1:0] i_uram_wr_data,
   output logic                        o_uram_en,
   output logic                        o_uram_wr_en,
   output logic [ADDR_W-1:0]           o_uram_addr,
   output logic [DATA_W-1:0]           o_uram_wr_data,
   output logic                        o_flush_req,
   input  logic                        i_flush_done,
   output logic [NUM_CORES-1:0]        o_done_mask,
   output logic [CNT_W-1:0]            o_flush_count
);

   localparam int IDX_W = arb_idx_w(NUM_CORES);
   localparam logic [NUM_CORES-1:0] ALL_DONE = {NUM_CORES{1'b1}};

   arb_state_t           state;
   logic [NUM_CORES-1:0] grant;
   logic [NUM_CORES-1:0] done_mask;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     gidx;
   logic                 flush_req;
   logic                 emptied;
   logic [CNT_W-1:0]     flush_count;

   logic [NUM_CORES-1:0] eligible;
   logic [NUM_CORES-1:0] pick;
   logic                 pick_vld;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     next_ptr;

   assign eligible = i_core_req & ~done_mask;

   rr_pick #(
      .NUM_CORES (NUM_CORES),
      .IDX_W     (IDX_W)
   ) u_rr_pick (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .pick     (pick),
      .valid    (pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (pick[k]) pick_idx = IDX_W'(k);
      end
   end

   assign next_ptr = (gidx == IDX_W'(NUM_CORES - 1)) ? '0 : gidx + IDX_W'(1);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= IDLE;
         grant       <= '0;
         gidx        <= '0;
         done_mask   <= '0;
         rr_ptr      <= '0;
         flush_req   <= 1'b0;
         emptied     <= 1'b0;
         flush_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant <= pick;
                  gidx  <= pick_idx;
                  state <= GRANT;
               end
            end
            GRANT: begin
               // Going back through IDLE guarantees one dead cycle between owners.
               if (!(i_core_req[gidx] | i_core_locked[gidx])) begin
                  grant           <= '0;
                  done_mask[gidx] <= 1'b1;
                  rr_ptr          <= next_ptr;
                  if ((done_mask | grant) == ALL_DONE) begin
                     flush_req <= 1'b1;
                     state     <= FLUSH;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            FLUSH: begin
               if (i_flush_done) begin
                  flush_req   <= 1'b0;
                  flush_count <= flush_count + CNT_W'(1);
                  emptied     <= 1'b1;
                  state       <= NOTIFY;
               end
            end
            NOTIFY: begin
               emptied   <= 1'b0;
               done_mask <= '0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Ungranted cores are invisible on the URAM port; no grant drives zeros.
   always_comb begin
      o_uram_en      = 1'b0;
      o_uram_wr_en   = 1'b0;
      o_uram_addr    = '0;
      o_uram_wr_data = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (grant[k]) begin
            o_uram_en      = i_uram_en[k];
            o_uram_wr_en   = i_uram_wr_en[k];
            o_uram_addr    = i_uram_addr[k*ADDR_W +: ADDR_W];
            o_uram_wr_data = i_uram_wr_data[k*DATA_W +: DATA_W];
         end
      end
   end

   assign o_core_grant   = grant;
   assign o_uram_emptied = {NUM_CORES{emptied}};
   assign o_flush_req    = flush_req;
   assign o_done_mask    = done_mask;
   assign o_flush_count  = flush_count;

endmodule

// File: tb/tb_uram_row_arbiter.sv
// Directed bench for uram_row_arbiter (4 cores): expected grant/flush/emptied events are queued
// by the stimulus and popped by an independent monitor; register/mux values are checked inline.
module tb_uram_row_arbiter;

   localparam int N  = 4;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int CW = 16;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    i_core_req;
   logic [N-1:0]    i_core_locked;
   logic [N-1:0]    o_core_grant;
   logic [N-1:0]    o_uram_emptied;
   logic [N-1:0]    i_uram_en;
   logic [N-1:0]    i_uram_wr_en;
   logic [N*AW-1:0] i_uram_addr;
   logic [N*DW-1:0] i_uram_wr_data;
   logic            o_uram_en;
   logic            o_uram_wr_en;
   logic [AW-1:0]   o_uram_addr;
   logic [DW-1:0]   o_uram_wr_data;
   logic            o_flush_req;
   logic            i_flush_done;
   logic [N-1:0]    o_done_mask;
   logic [CW-1:0]   o_flush_count;

   uram_row_arbiter #(
      .NUM_CORES (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .CNT_W     (CW)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .i_core_req     (i_core_req),
      .i_core_locked  (i_core_locked),
      .o_core_grant   (o_core_grant),
      .o_uram_emptied (o_uram_emptied),
      .i_uram_en      (i_uram_en),
      .i_uram_wr_en   (i_uram_wr_en),
      .i_uram_addr    (i_uram_addr),
      .i_uram_wr_data (i_uram_wr_data),
      .o_uram_en      (o_uram_en),
      .o_uram_wr_en   (o_uram_wr_en),
      .o_uram_addr    (o_uram_addr),
      .o_uram_wr_data (o_uram_wr_data),
      .o_flush_req    (o_flush_req),
      .i_flush_done   (i_flush_done),
      .o_done_mask    (o_done_mask),
      .o_flush_count  (o_flush_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 = new grant, 1 = emptied pulse, 2 = flush_req rises
   typedef struct {
      int           kind;
      logic [N-1:0] val;
      int           at;
   } evt_t;

   evt_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_evt(input int kind, input logic [N-1:0] val, input int at);
      evt_t e;
      e.kind = kind;
      e.val  = val;
      e.at   = at;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic observe(input int kind, input logic [N-1:0] val);
      evt_t e;
      vectors++;
      if (exp_q.size() == 0) begin
         miscompares++;
         $display("FAIL unexpected_event: kind %0d value %b at cycle %0d, none expected", kind, val, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.val !== val || e.at != cyc) begin
            miscompares++;
            $display("FAIL event: got kind %0d value %b cycle %0d, expected kind %0d value %b cycle %0d",
                     kind, val, cyc, e.kind, e.val, e.at);
         end
      end
   endtask

   logic [N-1:0] prev_grant = '0;
   logic         prev_emp   = 1'b0;
   logic         prev_fr    = 1'b0;

   always @(negedge clk) begin
      if (o_core_grant != '0 && o_core_grant != prev_grant) observe(0, o_core_grant);
      if (o_uram_emptied != '0 && !prev_emp)                observe(1, o_uram_emptied);
      if (o_flush_req && !prev_fr)                          observe(2, '0);
      prev_grant = o_core_grant;
      prev_emp   = (o_uram_emptied != '0);
      prev_fr    = o_flush_req;
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_grant"},      64'(o_core_grant),   64'h0);
      chk({tag, "_emptied"},    64'(o_uram_emptied), 64'h0);
      chk({tag, "_flush_req"},  64'(o_flush_req),    64'h0);
      chk({tag, "_done_mask"},  64'(o_done_mask),    64'h0);
      chk({tag, "_flush_cnt"},  64'(o_flush_count),  64'h0);
   endtask

   // One full session for core c; on the final core of an epoch the flush request follows.
   task automatic session(input int c, input bit last);
      i_core_req    = '0;
      i_core_req[c] = 1'b1;
      expect_evt(0, i_core_req, cyc + 1);
      tick(1);
      i_core_req = '0;
      if (last) expect_evt(2, '0, cyc + 1);
      tick(1);
   endtask

   initial begin
      reset          = 1'b0;
      i_core_req     = '0;
      i_core_locked  = '0;
      i_flush_done   = 1'b0;
      i_uram_en      = '0;
      i_uram_wr_en   = '0;
      i_uram_addr    = '0;
      i_uram_wr_data = '0;
      tick(2);
      check_reset_vals("reset");
      chk("reset_uram_en",   64'(o_uram_en),      64'h0);
      chk("reset_uram_addr", 64'(o_uram_addr),    64'h0);
      chk("reset_uram_data", 64'(o_uram_wr_data), 64'h0);
      reset = 1'b1;

      // stray drain completion while idle
      i_flush_done = 1'b1;
      tick(1);
      i_flush_done = 1'b0;
      tick(1);
      chk("stray_done_count", 64'(o_flush_count), 64'h0);

      // round robin: 1010 from ptr 0 -> core1, idle cycle, core3
      i_core_req = 4'b1010;
      expect_evt(0, 4'b0010, cyc + 1);
      tick(2);
      i_core_req = 4'b1000;
      expect_evt(0, 4'b1000, cyc + 2);
      tick(2);
      chk("rr_done_after_core1", 64'(o_done_mask), 64'h2);
      i_core_req = '0;
      tick(1);
      chk("rr_done_after_core3", 64'(o_done_mask), 64'ha);

      // lock hold: core2 drops req but stays locked while core0 waits
      i_core_req = 4'b0100;
      expect_evt(0, 4'b0100, cyc + 1);
      tick(1);
      i_core_req    = 4'b0001;
      i_core_locked = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("lock_hold_grant", 64'(o_core_grant), 64'h4);
      end
      i_core_locked = '0;
      expect_evt(0, 4'b0001, cyc + 2);
      tick(2);

      // mux isolation with core0 owning the port; core2 noise and lock must not leak
      i_uram_en                  = 4'b0101;
      i_uram_wr_en               = 4'b0001;
      i_uram_addr[0*AW +: AW]    = 12'h123;
      i_uram_wr_data[0*DW +: DW] = 32'hDEADBEEF;
      i_uram_addr[2*AW +: AW]    = 12'hFFF;
      i_uram_wr_data[2*DW +: DW] = 32'h55555555;
      i_core_locked              = 4'b0100;
      #1;
      chk("mux_en",    64'(o_uram_en),      64'h1);
      chk("mux_wr_en", 64'(o_uram_wr_en),   64'h1);
      chk("mux_addr",  64'(o_uram_addr),    64'h123);
      chk("mux_data",  64'(o_uram_wr_data), 64'hDEADBEEF);
      i_core_req = '0;
      expect_evt(2, '0, cyc + 1);
      tick(1);
      chk("nogrant_en",   64'(o_uram_en),      64'h0);
      chk("nogrant_addr", 64'(o_uram_addr),    64'h0);
      chk("nogrant_data", 64'(o_uram_wr_data), 64'h0);
      chk("barrier_done_full", 64'(o_done_mask), 64'hf);
      i_core_locked = '0;
      tick(1);
      chk("flush_req_held", 64'(o_flush_req), 64'h1);

      // barrier release
      i_flush_done = 1'b1;
      expect_evt(1, 4'b1111, cyc + 1);
      tick(1);
      i_flush_done = 1'b0;
      chk("flush_count_1", 64'(o_flush_count), 64'h1);
      chk("flush_req_drop", 64'(o_flush_req), 64'h0);
      tick(1);
      chk("emptied_one_cycle", 64'(o_uram_emptied), 64'h0);
      chk("done_cleared", 64'(o_done_mask), 64'h0);

      // done core1 re-requests; only core3 is served, a withdrawn core2 request is dropped
      i_core_req = 4'b0010;
      expect_evt(0, 4'b0010, cyc + 1);
      tick(1);
      i_core_req = '0;
      tick(1);
      i_core_req = 4'b1010;
      expect_evt(0, 4'b1000, cyc + 1);
      tick(1);
      i_core_req = 4'b1110;
      tick(1);
      i_core_req = 4'b1010;
      tick(1);
      i_core_req = 4'b0010;
      tick(3);
      chk("blocked_no_grant", 64'(o_core_grant), 64'h0);
      chk("blocked_done_mask", 64'(o_done_mask), 64'ha);
      i_core_req = 4'b0111;
      expect_evt(0, 4'b0001, cyc + 1);
      tick(1);
      i_core_req = 4'b0110;
      expect_evt(0, 4'b0100, cyc + 2);
      tick(2);
      i_core_req = 4'b0010;
      expect_evt(2, '0, cyc + 1);
      tick(1);
      i_flush_done = 1'b1;
      expect_evt(1, 4'b1111, cyc + 1);
      tick(1);
      i_flush_done = 1'b0;
      chk("flush_count_2", 64'(o_flush_count), 64'h2);
      expect_evt(0, 4'b0010, cyc + 2);
      tick(2);
      chk("core1_after_notify", 64'(o_core_grant), 64'h2);

      // reset while granted
      reset      = 1'b0;
      i_core_req = '0;
      tick(1);
      check_reset_vals("rst_grant");
      reset = 1'b1;

      // full epoch, then reset while flushing
      session(0, 1'b0);
      session(1, 1'b0);
      session(2, 1'b0);
      session(3, 1'b1);
      chk("epoch3_flush_req", 64'(o_flush_req), 64'h1);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      check_reset_vals("rst_flush");
      i_flush_done = 1'b1;
      tick(1);
      i_flush_done = 1'b0;
      tick(3);
      chk("post_reset_count", 64'(o_flush_count), 64'h0);
      chk("post_reset_emptied", 64'(o_uram_emptied), 64'h0);

      tick(2);
      chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
